// File: rtl/axis_adc_4ch_decimator_if.sv
// =====================================================================
// axis_adc_4ch_decimator_if : AXI-Stream valid/ready/data bundle
// Rev 1.0
// =====================================================================
`default_nettype none

interface axis_adc_4ch_decimator_if #(
   parameter int TDATA_WIDTH = 64
) ();
   logic                   tvalid;
   logic                   tready;
   logic [TDATA_WIDTH-1:0] tdata;

   modport master (
      output tvalid,
      output tdata,
      input  tready
   );

   modport slave (
      input  tvalid,
      input  tdata,
      output tready
   );
endinterface

`default_nettype wire

// File: rtl/axis_adc_4ch_decimator.sv
// =====================================================================
// axis_adc_4ch_decimator : 4-channel block-average decimator with
// saturation and sticky overrun on output back-pressure.
// Rev 1.0
// =====================================================================
`default_nettype none

module axis_adc_4ch_decimator #(
   parameter int DATA_WIDTH = 16,
   parameter int CNTR_WIDTH = 16,
   parameter int ACC_WIDTH  = 32
) (
   input  wire logic                  aclk,
   input  wire logic                  areset,
   input  wire logic [CNTR_WIDTH-1:0] cfg_rate,
   input  wire logic [4:0]            cfg_shift,
   input  wire logic                  cfg_clr,
   output logic                       sts_overrun,
   axis_adc_4ch_decimator_if.slave    s_axis,
   axis_adc_4ch_decimator_if.master   m_axis
);

   localparam int c_num_ch = 4;
   localparam int c_bus_w  = c_num_ch * DATA_WIDTH;

   localparam logic signed [ACC_WIDTH-1:0] c_sat_max =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] c_sat_min =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   logic [CNTR_WIDTH-1:0]        count_q, count_d;
   logic [CNTR_WIDTH-1:0]        active_rate_q, active_rate_d;
   logic [4:0]                   active_shift_q, active_shift_d;
   logic signed [ACC_WIDTH-1:0]  acc_q [c_num_ch];
   logic signed [ACC_WIDTH-1:0]  acc_d [c_num_ch];
   logic                         out_valid_q, out_valid_d;
   logic [c_bus_w-1:0]           out_data_q, out_data_d;
   logic                         overrun_q, overrun_d;

   logic                         w_accept;
   logic                         w_block_start;
   logic [CNTR_WIDTH-1:0]        w_rate_cfg;
   logic [CNTR_WIDTH-1:0]        w_rate_cur;
   logic [4:0]                   w_shift_cur;
   logic                         w_last;
   logic                         w_dump;
   logic                         w_load_ok;
   logic                         w_drop;
   logic signed [DATA_WIDTH-1:0] w_sample  [c_num_ch];
   logic signed [ACC_WIDTH-1:0]  w_sum     [c_num_ch];
   logic signed [ACC_WIDTH-1:0]  w_shifted [c_num_ch];
   logic [c_bus_w-1:0]           w_avg;

   // The block's rate/shift come from cfg on its first sample, from the latched copy afterwards.
   always_comb begin
      w_accept      = s_axis.tvalid;
      w_block_start = (count_q == '0);
      w_rate_cfg    = (cfg_rate == '0) ? CNTR_WIDTH'(1) : cfg_rate;
      w_rate_cur    = w_block_start ? w_rate_cfg : active_rate_q;
      w_shift_cur   = w_block_start ? cfg_shift  : active_shift_q;
      w_last        = (count_q == (w_rate_cur - CNTR_WIDTH'(1)));
      w_dump        = w_accept && w_last;
      w_load_ok     = !out_valid_q || m_axis.tready;
      w_drop        = w_dump && !w_load_ok;
   end

   always_comb begin
      w_avg = '0;
      for (int c = 0; c < c_num_ch; c++) begin
         w_sample[c]  = s_axis.tdata[c*DATA_WIDTH +: DATA_WIDTH];
         w_sum[c]     = (w_block_start ? '0 : acc_q[c]) + ACC_WIDTH'(w_sample[c]);
         w_shifted[c] = w_sum[c] >>> w_shift_cur;
         if (w_shifted[c] > c_sat_max) begin
            w_avg[c*DATA_WIDTH +: DATA_WIDTH] = c_sat_max[DATA_WIDTH-1:0];
         end else if (w_shifted[c] < c_sat_min) begin
            w_avg[c*DATA_WIDTH +: DATA_WIDTH] = c_sat_min[DATA_WIDTH-1:0];
         end else begin
            w_avg[c*DATA_WIDTH +: DATA_WIDTH] = w_shifted[c][DATA_WIDTH-1:0];
         end
      end
   end

   always_comb begin
      count_d        = count_q;
      active_rate_d  = active_rate_q;
      active_shift_d = active_shift_q;
      for (int c = 0; c < c_num_ch; c++) begin
         acc_d[c] = acc_q[c];
      end

      if (w_accept) begin
         if (w_block_start) begin
            active_rate_d  = w_rate_cfg;
            active_shift_d = cfg_shift;
         end
         for (int c = 0; c < c_num_ch; c++) begin
            acc_d[c] = w_sum[c];
         end
         count_d = w_last ? '0 : (count_q + CNTR_WIDTH'(1));
      end
   end

   // A dropped block leaves the output register untouched; the accumulator restarts regardless.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      overrun_d   = overrun_q;

      if (w_dump && w_load_ok) begin
         out_valid_d = 1'b1;
         out_data_d  = w_avg;
      end else if (!w_dump && out_valid_q && m_axis.tready) begin
         out_valid_d = 1'b0;
      end

      if (cfg_clr) begin
         overrun_d = 1'b0;
      end
      if (w_drop) begin
         overrun_d = 1'b1;
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         count_q        <= '0;
         active_rate_q  <= CNTR_WIDTH'(1);
         active_shift_q <= '0;
         for (int c = 0; c < c_num_ch; c++) begin
            acc_q[c] <= '0;
         end
         out_valid_q    <= 1'b0;
         out_data_q     <= '0;
         overrun_q      <= 1'b0;
      end else begin
         count_q        <= count_d;
         active_rate_q  <= active_rate_d;
         active_shift_q <= active_shift_d;
         for (int c = 0; c < c_num_ch; c++) begin
            acc_q[c] <= acc_d[c];
         end
         out_valid_q    <= out_valid_d;
         out_data_q     <= out_data_d;
         overrun_q      <= overrun_d;
      end
   end

   assign s_axis.tready = 1'b1;
   assign m_axis.tvalid = out_valid_q;
   assign m_axis.tdata  = out_data_q;
   assign sts_overrun   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_axis_adc_4ch_decimator.sv
// =====================================================================
// tb_axis_adc_4ch_decimator : directed and randomized checks against a
// block-list reference model.
// Rev 1.0
// =====================================================================
`default_nettype none

module tb_axis_adc_4ch_decimator;

   logic        aclk = 1'b0;
   logic        areset;
   logic [15:0] cfg_rate;
   logic [4:0]  cfg_shift;
   logic        cfg_clr;
   logic        sts_overrun;

   axis_adc_4ch_decimator_if #(.TDATA_WIDTH(64)) s_axis ();
   axis_adc_4ch_decimator_if #(.TDATA_WIDTH(64)) m_axis ();

   always #5 aclk = ~aclk;

   axis_adc_4ch_decimator dut (
      .aclk        (aclk),
      .areset      (areset),
      .cfg_rate    (cfg_rate),
      .cfg_shift   (cfg_shift),
      .cfg_clr     (cfg_clr),
      .sts_overrun (sts_overrun),
      .s_axis      (s_axis),
      .m_axis      (m_axis)
   );

   int          tests = 0;
   int          fails = 0;

   // Reference model: samples of the open block, plus the expected output register.
   logic [63:0] blk_q [$];
   int          blk_rate;
   int          blk_shift;
   logic        exp_valid;
   logic [63:0] exp_data;
   logic        exp_ovr;

   function automatic logic [63:0] pack(input int c3, input int c2, input int c1, input int c0);
      logic [31:0] a3, a2, a1, a0;
      a3 = c3; a2 = c2; a1 = c1; a0 = c0;
      return {a3[15:0], a2[15:0], a1[15:0], a0[15:0]};
   endfunction

   function automatic logic [63:0] avg_block(input int shift);
      logic [63:0]        res;
      logic [63:0]        e;
      logic signed [15:0] x;
      longint             s;
      res = '0;
      for (int c = 0; c < 4; c++) begin
         s = 0;
         for (int i = 0; i < blk_q.size(); i++) begin
            e = blk_q[i];
            x = e[c*16 +: 16];
            s = s + longint'(x);
         end
         s = s >>> shift;
         if (s > 32767) s = 32767;
         else if (s < -32768) s = -32768;
         res[c*16 +: 16] = s[15:0];
      end
      return res;
   endfunction

   task automatic model_reset();
      blk_q.delete();
      exp_valid = 1'b0;
      exp_data  = '0;
      exp_ovr   = 1'b0;
   endtask

   // One clock: present inputs, advance the model at the edge, leave outputs ready to sample.
   task automatic cycle(input logic v, input logic [63:0] d, input logic rdy, input logic clr);
      logic        dump;
      logic        drop;
      logic [63:0] word;
      dump = 1'b0;
      word = '0;
      s_axis.tvalid = v;
      s_axis.tdata  = d;
      m_axis.tready = rdy;
      cfg_clr       = clr;
      @(posedge aclk);
      if (v) begin
         if (blk_q.size() == 0) begin
            blk_rate  = (cfg_rate == 16'd0) ? 1 : int'(cfg_rate);
            blk_shift = int'(cfg_shift);
         end
         blk_q.push_back(d);
         if (blk_q.size() == blk_rate) begin
            word = avg_block(blk_shift);
            blk_q.delete();
            dump = 1'b1;
         end
      end
      drop = dump && exp_valid && !rdy;
      if (dump && !drop) begin
         exp_valid = 1'b1;
         exp_data  = word;
      end else if (!dump && exp_valid && rdy) begin
         exp_valid = 1'b0;
      end
      if (clr)  exp_ovr = 1'b0;
      if (drop) exp_ovr = 1'b1;
      #1;
      s_axis.tvalid = 1'b0;
      cfg_clr       = 1'b0;
   endtask

   task automatic test_reset();
      areset = 1'b1;
      cfg_rate = 16'd1; cfg_shift = 5'd0; cfg_clr = 1'b0;
      s_axis.tvalid = 1'b0; s_axis.tdata = '0; m_axis.tready = 1'b0;
      model_reset();
      repeat (3) @(posedge aclk);
      #1;
      tests++;
      if ({m_axis.tvalid, m_axis.tdata, sts_overrun} !== 66'd0) begin
         fails++;
         $display("FAIL reset_state: got valid=%b data=%h ovr=%b, want 0/0/0",
                  m_axis.tvalid, m_axis.tdata, sts_overrun);
      end
      tests++;
      if (s_axis.tready !== 1'b1) begin
         fails++;
         $display("FAIL s_tready: got %b, want 1", s_axis.tready);
      end
      areset = 1'b0;
   endtask

   task automatic test_passthrough();
      logic [63:0] w;
      cfg_rate = 16'd1; cfg_shift = 5'd0;
      w = pack(100, -5, 32767, -32768);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, w, 1'b1, 1'b0);
         tests++;
         if ({m_axis.tvalid, m_axis.tdata} !== {1'b1, w}) begin
            fails++;
            $display("FAIL passthrough[%0d]: got %b/%h, want 1/%h", i, m_axis.tvalid, m_axis.tdata, w);
         end
      end
      cycle(1'b0, '0, 1'b1, 1'b0);
      tests++;
      if ({m_axis.tvalid, sts_overrun} !== 2'b00) begin
         fails++;
         $display("FAIL passthrough_idle: got valid=%b ovr=%b, want 0/0", m_axis.tvalid, sts_overrun);
      end
   endtask

   task automatic test_average();
      logic [63:0] want;
      cfg_rate = 16'd4; cfg_shift = 5'd2;
      for (int i = 1; i <= 4; i++) begin
         cycle(1'b1, pack(0, 0, -3, i), 1'b1, 1'b0);
         if (i < 4) begin
            tests++;
            if (m_axis.tvalid !== 1'b0) begin
               fails++;
               $display("FAIL average_early[%0d]: got valid=%b, want 0", i, m_axis.tvalid);
            end
         end
      end
      want = pack(0, 0, -3, 2);
      tests++;
      if ({m_axis.tvalid, m_axis.tdata} !== {1'b1, want}) begin
         fails++;
         $display("FAIL average_word: got %b/%h, want 1/%h", m_axis.tvalid, m_axis.tdata, want);
      end
      cycle(1'b0, '0, 1'b1, 1'b0);
   endtask

   task automatic test_saturate();
      logic [63:0] want;
      cfg_rate = 16'd4; cfg_shift = 5'd0;
      for (int i = 0; i < 4; i++) cycle(1'b1, pack(-1, 20000, -32768, 32767), 1'b1, 1'b0);
      want = pack(-4, 32767, -32768, 32767);
      tests++;
      if ({m_axis.tvalid, m_axis.tdata} !== {1'b1, want}) begin
         fails++;
         $display("FAIL saturate_word: got %b/%h, want 1/%h", m_axis.tvalid, m_axis.tdata, want);
      end
      cycle(1'b0, '0, 1'b1, 1'b0);
   endtask

   task automatic test_overrun();
      logic [63:0] first;
      cfg_rate = 16'd2; cfg_shift = 5'd1;
      first = pack(0, 0, 0, 15);
      cycle(1'b1, pack(0, 0, 0, 10), 1'b0, 1'b0);
      cycle(1'b1, pack(0, 0, 0, 20), 1'b0, 1'b0);
      tests++;
      if ({m_axis.tvalid, m_axis.tdata, sts_overrun} !== {1'b1, first, 1'b0}) begin
         fails++;
         $display("FAIL overrun_first: got %b/%h ovr=%b, want 1/%h ovr=0",
                  m_axis.tvalid, m_axis.tdata, sts_overrun, first);
      end
      for (int b = 0; b < 2; b++) begin
         cycle(1'b1, pack(0, 0, 0, 100), 1'b0, 1'b0);
         cycle(1'b1, pack(0, 0, 0, 200), 1'b0, 1'b0);
         tests++;
         if ({m_axis.tvalid, m_axis.tdata, sts_overrun} !== {1'b1, first, 1'b1}) begin
            fails++;
            $display("FAIL overrun_drop[%0d]: got %b/%h ovr=%b, want 1/%h ovr=1",
                     b, m_axis.tvalid, m_axis.tdata, sts_overrun, first);
         end
      end
      cycle(1'b0, '0, 1'b0, 1'b1);
      tests++;
      if ({m_axis.tvalid, sts_overrun} !== 2'b10) begin
         fails++;
         $display("FAIL overrun_clear: got valid=%b ovr=%b, want 1/0", m_axis.tvalid, sts_overrun);
      end
      cycle(1'b1, pack(0, 0, 0, 1), 1'b0, 1'b0);
      cycle(1'b1, pack(0, 0, 0, 1), 1'b0, 1'b1);
      tests++;
      if ({m_axis.tdata, sts_overrun} !== {first, 1'b1}) begin
         fails++;
         $display("FAIL overrun_set_wins: got %h ovr=%b, want %h ovr=1", m_axis.tdata, sts_overrun, first);
      end
      cycle(1'b0, '0, 1'b1, 1'b0);
      tests++;
      if (m_axis.tvalid !== 1'b0) begin
         fails++;
         $display("FAIL overrun_drain: got valid=%b, want 0", m_axis.tvalid);
      end
   endtask

   task automatic test_rate_change();
      cfg_rate = 16'd4; cfg_shift = 5'd0;
      cycle(1'b1, pack(0, 0, 0, 1), 1'b1, 1'b0);
      cfg_rate = 16'd2;
      cycle(1'b0, '0, 1'b1, 1'b0);
      cycle(1'b1, pack(0, 0, 0, 2), 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      cycle(1'b1, pack(0, 0, 0, 3), 1'b1, 1'b0);
      tests++;
      if (m_axis.tvalid !== 1'b0) begin
         fails++;
         $display("FAIL rate_hold: got valid=%b after 3 of 4, want 0", m_axis.tvalid);
      end
      cycle(1'b0, '0, 1'b1, 1'b0);
      cycle(1'b1, pack(0, 0, 0, 4), 1'b1, 1'b0);
      tests++;
      if ({m_axis.tvalid, m_axis.tdata} !== {1'b1, pack(0, 0, 0, 10)}) begin
         fails++;
         $display("FAIL rate_old_block: got %b/%h, want 1/%h", m_axis.tvalid, m_axis.tdata, pack(0, 0, 0, 10));
      end
      cycle(1'b1, pack(0, 0, 0, 5), 1'b1, 1'b0);
      tests++;
      if (m_axis.tvalid !== 1'b0) begin
         fails++;
         $display("FAIL rate_new_mid: got valid=%b, want 0", m_axis.tvalid);
      end
      cycle(1'b1, pack(0, 0, 0, 6), 1'b1, 1'b0);
      tests++;
      if ({m_axis.tvalid, m_axis.tdata} !== {1'b1, pack(0, 0, 0, 11)}) begin
         fails++;
         $display("FAIL rate_new_block: got %b/%h, want 1/%h", m_axis.tvalid, m_axis.tdata, pack(0, 0, 0, 11));
      end
      cfg_rate = 16'd0;
      for (int i = 7; i <= 8; i++) begin
         cycle(1'b1, pack(0, 0, 0, i), 1'b1, 1'b0);
         tests++;
         if ({m_axis.tvalid, m_axis.tdata} !== {1'b1, pack(0, 0, 0, i)}) begin
            fails++;
            $display("FAIL rate_zero[%0d]: got %b/%h, want 1/%h", i, m_axis.tvalid, m_axis.tdata, pack(0, 0, 0, i));
         end
      end
   endtask

   task automatic test_reset_midblock();
      cfg_rate = 16'd4; cfg_shift = 5'd0;
      for (int i = 0; i < 3; i++) cycle(1'b1, pack(0, 0, 0, 1000), 1'b1, 1'b0);
      areset = 1'b1;
      #2;
      tests++;
      if ({m_axis.tvalid, m_axis.tdata, sts_overrun} !== 66'd0) begin
         fails++;
         $display("FAIL reset_async: got valid=%b data=%h ovr=%b, want 0/0/0",
                  m_axis.tvalid, m_axis.tdata, sts_overrun);
      end
      model_reset();
      repeat (2) @(posedge aclk);
      #1;
      areset = 1'b0;
      for (int i = 1; i <= 3; i++) cycle(1'b1, pack(0, 0, 0, 1), 1'b1, 1'b0);
      tests++;
      if (m_axis.tvalid !== 1'b0) begin
         fails++;
         $display("FAIL reset_restart_early: got valid=%b after 3 samples, want 0", m_axis.tvalid);
      end
      cycle(1'b1, pack(0, 0, 0, 1), 1'b1, 1'b0);
      tests++;
      if ({m_axis.tvalid, m_axis.tdata} !== {1'b1, pack(0, 0, 0, 4)}) begin
         fails++;
         $display("FAIL reset_restart_word: got %b/%h, want 1/%h", m_axis.tvalid, m_axis.tdata, pack(0, 0, 0, 4));
      end
      cycle(1'b0, '0, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      logic [63:0] d;
      int          bad;
      bad = 0;
      for (int n = 0; n < 600; n++) begin
         if (n % 60 == 0) begin
            cfg_rate  = 16'($urandom_range(0, 5));
            cfg_shift = 5'($urandom_range(0, 3));
         end
         d = {$urandom, $urandom};
         cycle(($urandom_range(0, 9) < 7), d, ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));
         tests++;
         if ({m_axis.tvalid, m_axis.tdata} !== {exp_valid, exp_data}) begin
            fails++;
            if (bad++ < 10)
               $display("FAIL random_out[%0d]: got %b/%h, want %b/%h",
                        n, m_axis.tvalid, m_axis.tdata, exp_valid, exp_data);
         end
         tests++;
         if (sts_overrun !== exp_ovr) begin
            fails++;
            if (bad++ < 10)
               $display("FAIL random_ovr[%0d]: got %b, want %b", n, sts_overrun, exp_ovr);
         end
      end
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_average();
      test_saturate();
      test_overrun();
      test_rate_change();
      test_reset_midblock();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
